pipeline_nsew_fifo: RTL and testbench
=====================================

Name: pipeline_nsew_fifo

Overview:
- Parametrised successor to the four-direction (N/S/E/W) inter-router pipeline stage.
- Buffers groups of four flits, one per direction, captured in the same cycle; a group is pushed and popped as a unit.
- Adds a valid/ready handshake on both sides, a per-lane presence mask, occupancy reporting and a synchronous flush.
- Sits between a router's crossbar output and the link to the next router.

Parameters:
FLIT_W, 10, width of each directional flit
DEPTH, 3, number of four-flit groups stored; legal range 2..16
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override)

Ports:
clk  in  1  rising-edge clock, sole clock domain
rst_n  in  1  reset, synchronous, active-low
flush  in  1  synchronous clear of all stored groups
in_valid  in  1  upstream presents a group
in_ready  out  1  stage accepts a group this cycle
in_mask  in  4  lane presence, bit3=N, bit2=S, bit1=E, bit0=W
nty  in  FLIT_W  north flit in
sty  in  FLIT_W  south flit in
ety  in  FLIT_W  east flit in
wty  in  FLIT_W  west flit in
out_valid  out  1  head group available
out_ready  in  1  downstream takes head group
out_mask  out  4  lane presence of head group, same bit order as in_mask
nxt  out  FLIT_W  north flit out
sxt  out  FLIT_W  south flit out
ext  out  FLIT_W  east flit out
wxt  out  FLIT_W  west flit out
count  out  CNT_W  groups currently stored, 0..DEPTH

Behaviour:
- Reset (rst_n=0 at a rising edge): wr_ptr, rd_ptr and count go to 0. Outputs out_valid=0, out_mask=0, nxt/sxt/ext/wxt=0. in_ready=1 from the first cycle after reset. Storage contents are don't-care.
- Storage: circular buffer of DEPTH entries, each {mask[3:0], N, S, E, W}. Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
- Push: in_valid & in_ready at a rising edge. Writes the entry at wr_ptr and advances wr_ptr.
  - Lanes with in_mask bit = 0 are stored as all-zero flits, whatever is on the input bus.
  - in_mask = 0 with in_valid = 1 is legal: it pushes an empty group that occupies a slot.
- Pop: out_valid & out_ready at a rising edge. Advances rd_ptr.
- Output timing: first-word-fall-through from registered storage. Data is driven combinationally from the entry at rd_ptr.
  - A group pushed at edge t is visible with out_valid=1 after edge t. Latency is 1 cycle; there is no empty-bypass path.
- When count = 0: out_valid=0, out_mask=0, all flit outputs 0. High-impedance is never driven.
- in_ready = (count < DEPTH), depending only on registered state. No combinational path from out_ready to in_ready. When full, a pop in the same cycle does not enable a push.
- Simultaneous push and pop (count between 1 and DEPTH-1): both occur and count is unchanged.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds DEPTH and never underflows.
- in_valid while in_ready=0: the input is ignored. Upstream must hold it.
- out_valid stays high and output data stays stable until popped.
- Flush at a rising edge clears pointers and count to 0, overriding any push or pop in that cycle (the pushed group is discarded). Outputs read empty after that edge.
- Priority: rst_n > flush > push/pop.
- Reset or flush mid-stream: all stored groups are lost. No partial-group state exists.
- Group ordering is strict FIFO. Lanes within a group are never reordered or split.

Test Plan:
- Reset then idle: after rst_n low for 2 cycles then high -> count=0, out_valid=0, in_ready=1, nxt=sxt=ext=wxt=0, out_mask=0.
- Single group: push N=0x001, S=0x002, E=0x003, W=0x004 with mask=1111 at edge 1, out_ready=0 -> after edge 1: out_valid=1, nxt=0x001, wxt=0x004, count=1. Raise out_ready -> after the next edge: out_valid=0, count=0.
- Fill and backpressure, DEPTH=3: push groups G1..G4 back-to-back with out_ready=0 -> count=3, in_ready=0, G4 held. Pop G1 -> in_ready=1, then G4 accepted. Drain order is G1, G2, G3, G4.
- Mask zeroing: push mask=1010 with all inputs 0x3FF -> nxt=0x3FF, sxt=0, ext=0x3FF, wxt=0, out_mask=1010. Push mask=0000 -> count increments and the group pops with all outputs 0.
- Wrap and concurrency, DEPTH=3: hold count=2 with push and pop every cycle for 10 cycles -> count stays 2, pointers wrap at least 3 times, output sequence equals input sequence.
- Flush vs push: count=2, assert flush together with in_valid -> next cycle count=0, out_valid=0, the pushed group is absent. Reset asserted with count=3 -> count=0 after the edge.

Source files
------------

// File: rtl/pipeline_nsew_fifo.sv
// pipeline_nsew_fifo: FIFO of N/S/E/W flit groups with valid/ready, lane masks, occupancy and flush.
// First-word-fall-through from registered storage; a group is always pushed and popped whole.
module pipeline_nsew_fifo #(
    parameter int FLIT_W = 10,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mask,
    input  logic [FLIT_W-1:0] nty,
    input  logic [FLIT_W-1:0] sty,
    input  logic [FLIT_W-1:0] ety,
    input  logic [FLIT_W-1:0] wty,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_mask,
    output logic [FLIT_W-1:0] nxt,
    output logic [FLIT_W-1:0] sxt,
    output logic [FLIT_W-1:0] ext,
    output logic [FLIT_W-1:0] wxt,
    output logic [CNT_W-1:0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 4 + 4 * FLIT_W;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] wdata, head;
    logic          push, pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = count < CNT_W'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    // Absent lanes are stored as zero so the link never sees stale bus values
    assign wdata = {in_mask,
                    in_mask[3] ? nty : '0,
                    in_mask[2] ? sty : '0,
                    in_mask[1] ? ety : '0,
                    in_mask[0] ? wty : '0};
    assign head = out_valid ? mem[rd_ptr] : '0;
    assign {out_mask, nxt, sxt, ext, wxt} = head;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop) rd_ptr <= inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: tb/tb_pipeline_nsew_fifo.sv
// tb_pipeline_nsew_fifo: directed checks of reset, push/pop, backpressure, masking, wrap and flush.
module tb_pipeline_nsew_fifo;
    localparam int FW = 10;
    localparam int D = 3;
    localparam int CW = $clog2(D + 1);

    logic          clk = 0;
    logic          rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic          in_ready, out_valid;
    logic [3:0]    in_mask = 0, out_mask;
    logic [FW-1:0] nty = 0, sty = 0, ety = 0, wty = 0;
    logic [FW-1:0] nxt, sxt, ext, wxt;
    logic [CW-1:0] count;
    int vectors = 0, miscompares = 0;

    pipeline_nsew_fifo #(.FLIT_W(FW), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_mask(in_mask), .nty(nty), .sty(sty), .ety(ety), .wty(wty),
        .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
        .nxt(nxt), .sxt(sxt), .ext(ext), .wxt(wxt), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] m, input logic [FW-1:0] n, s, e, w);
        in_valid = v; in_mask = m; nty = n; sty = s; ety = e; wty = w;
    endtask

    function automatic logic [4*FW+3:0] grp(input logic [3:0] m, input logic [FW-1:0] n, s, e, w);
        return {m, m[3] ? n : 10'h0, m[2] ? s : 10'h0, m[1] ? e : 10'h0, m[0] ? w : 10'h0};
    endfunction

    function automatic logic [FW-1:0] fn(input int k);
        return FW'(k * 37 + 5);
    endfunction

    function automatic logic [FW-1:0] fs(input int k);
        return FW'(k * 53 + 9);
    endfunction

    task automatic test_reset();
        rst_n = 0; tick(); tick(); rst_n = 1; tick();
        vectors++;
        if ({out_valid, in_ready, count, out_mask, nxt, sxt, ext, wxt} !== {1'b0, 1'b1, CW'(0), 44'h0}) begin
            miscompares++;
            $display("FAIL reset: got v=%b rdy=%b cnt=%0d mask=%b flits=%h %h %h %h, want 0 1 0 0 0",
                     out_valid, in_ready, count, out_mask, nxt, sxt, ext, wxt);
        end
    endtask

    task automatic test_single();
        drive(1, 4'hf, 10'h001, 10'h002, 10'h003, 10'h004); out_ready = 0;
        tick(); drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if ({out_valid, count, out_mask, nxt, sxt, ext, wxt} !== {1'b1, CW'(1), grp(4'hf, 10'h001, 10'h002, 10'h003, 10'h004)}) begin
            miscompares++;
            $display("FAIL single_head: got v=%b cnt=%0d mask=%b %h %h %h %h, want 1 1 1111 001 002 003 004",
                     out_valid, count, out_mask, nxt, sxt, ext, wxt);
        end
        out_ready = 1; tick(); out_ready = 0;
        vectors++;
        if ({out_valid, count} !== {1'b0, CW'(0)}) begin
            miscompares++;
            $display("FAIL single_pop: got v=%b cnt=%0d, want 0 0", out_valid, count);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            drive(1, 4'hf, fn(i), fs(i), ~fn(i), fn(i) ^ fs(i)); tick();
        end
        vectors++;
        if ({count, in_ready, out_mask, nxt, sxt, ext, wxt} !== {CW'(3), 1'b0, grp(4'hf, fn(1), fs(1), ~fn(1), fn(1) ^ fs(1))}) begin
            miscompares++;
            $display("FAIL fill_full: got cnt=%0d rdy=%b head=%h %h, want 3 0 G1", count, in_ready, nxt, sxt);
        end
        out_ready = 1; tick(); out_ready = 0;
        vectors++;
        if ({count, in_ready, nxt} !== {CW'(2), 1'b1, fn(2)}) begin
            miscompares++;
            $display("FAIL fill_pop1: got cnt=%0d rdy=%b nxt=%h, want 2 1 %h", count, in_ready, nxt, fn(2));
        end
        tick(); drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if ({count, in_ready} !== {CW'(3), 1'b0}) begin
            miscompares++;
            $display("FAIL fill_g4: got cnt=%0d rdy=%b, want 3 0", count, in_ready);
        end
        out_ready = 1;
        for (int i = 2; i <= 4; i++) begin
            vectors++;
            if ({out_valid, out_mask, nxt, sxt, ext, wxt} !== {1'b1, grp(4'hf, fn(i), fs(i), ~fn(i), fn(i) ^ fs(i))}) begin
                miscompares++;
                $display("FAIL drain_G%0d: got v=%b %h %h %h %h, want 1 %h %h %h %h", i, out_valid, nxt, sxt, ext, wxt,
                         fn(i), fs(i), ~fn(i), fn(i) ^ fs(i));
            end
            tick();
        end
        out_ready = 0;
        vectors++;
        if ({out_valid, count} !== {1'b0, CW'(0)}) begin
            miscompares++;
            $display("FAIL drain_empty: got v=%b cnt=%0d, want 0 0", out_valid, count);
        end
    endtask

    task automatic test_mask();
        drive(1, 4'b1010, 10'h3ff, 10'h3ff, 10'h3ff, 10'h3ff); tick();
        vectors++;
        if ({count, out_mask, nxt, sxt, ext, wxt} !== {CW'(1), 4'b1010, 10'h3ff, 10'h0, 10'h3ff, 10'h0}) begin
            miscompares++;
            $display("FAIL mask_1010: got cnt=%0d mask=%b %h %h %h %h, want 1 1010 3ff 000 3ff 000",
                     count, out_mask, nxt, sxt, ext, wxt);
        end
        drive(1, 4'b0000, 10'h3ff, 10'h3ff, 10'h3ff, 10'h3ff); tick(); drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if (count !== CW'(2)) begin
            miscompares++;
            $display("FAIL mask_empty_push: got cnt=%0d, want 2", count);
        end
        out_ready = 1; tick(); out_ready = 0;
        vectors++;
        if ({out_valid, count, out_mask, nxt, sxt, ext, wxt} !== {1'b1, CW'(1), 44'h0}) begin
            miscompares++;
            $display("FAIL mask_empty_group: got v=%b cnt=%0d mask=%b %h %h %h %h, want 1 1 0 0",
                     out_valid, count, out_mask, nxt, sxt, ext, wxt);
        end
        out_ready = 1; tick(); out_ready = 0;
        vectors++;
        if (count !== CW'(0)) begin
            miscompares++;
            $display("FAIL mask_drain: got cnt=%0d, want 0", count);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            drive(1, 4'hf, fn(k + 20), fs(k + 20), ~fn(k + 20), fn(k + 20) ^ fs(k + 20)); tick();
        end
        out_ready = 1;
        for (int k = 0; k < 10; k++) begin
            drive(1, 4'hf, fn(k + 22), fs(k + 22), ~fn(k + 22), fn(k + 22) ^ fs(k + 22));
            vectors++;
            if ({count, nxt, sxt, ext, wxt} !== {CW'(2), fn(k + 20), fs(k + 20), ~fn(k + 20), fn(k + 20) ^ fs(k + 20)}) begin
                miscompares++;
                $display("FAIL wrap_%0d: got cnt=%0d %h %h, want 2 %h %h", k, count, nxt, sxt, fn(k + 20), fs(k + 20));
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 10; k < 12; k++) begin
            vectors++;
            if ({out_valid, nxt, sxt, ext, wxt} !== {1'b1, fn(k + 20), fs(k + 20), ~fn(k + 20), fn(k + 20) ^ fs(k + 20)}) begin
                miscompares++;
                $display("FAIL wrap_tail_%0d: got v=%b %h %h, want 1 %h %h", k, out_valid, nxt, sxt, fn(k + 20), fs(k + 20));
            end
            tick();
        end
        out_ready = 0;
        vectors++;
        if (count !== CW'(0)) begin
            miscompares++;
            $display("FAIL wrap_end: got cnt=%0d, want 0", count);
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 2; k++) begin
            drive(1, 4'hf, fn(k + 40), fs(k + 40), 10'h1, 10'h2); tick();
        end
        flush = 1; drive(1, 4'hf, 10'h155, 10'h2aa, 10'h0f0, 10'h00f); tick();
        flush = 0; drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if ({count, out_valid, in_ready, out_mask, nxt, sxt, ext, wxt} !== {CW'(0), 1'b0, 1'b1, 44'h0}) begin
            miscompares++;
            $display("FAIL flush: got cnt=%0d v=%b rdy=%b mask=%b %h, want 0 0 1 0 0", count, out_valid, in_ready, out_mask, nxt);
        end
        tick();
        vectors++;
        if ({count, out_valid} !== {CW'(0), 1'b0}) begin
            miscompares++;
            $display("FAIL flush_discard: got cnt=%0d v=%b, want 0 0", count, out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1, 4'hf, fn(k), fs(k), 10'h3, 10'h4); tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if (count !== CW'(3)) begin
            miscompares++;
            $display("FAIL prereset_full: got cnt=%0d, want 3", count);
        end
        rst_n = 0; tick(); rst_n = 1;
        vectors++;
        if ({count, out_valid, in_ready, nxt} !== {CW'(0), 1'b0, 1'b1, 10'h0}) begin
            miscompares++;
            $display("FAIL reset_midstream: got cnt=%0d v=%b rdy=%b nxt=%h, want 0 0 1 0", count, out_valid, in_ready, nxt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_mask();
        test_back_to_back();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
